// File: rtl/pluto_spi_servo_frame.sv
// Pluto SPI servo frame slave: double-buffered PWM/dout writes committed per
// frame, snapshotted quad/din/status reads, and a host-silence watchdog.
module pluto_spi_servo_frame #(
    parameter int NCH       = 4,
    parameter int PWMBITS   = 11,
    parameter int DOUTW     = 10,
    parameter int WD_CYCLES = 4000000
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              SCK,
    input  logic              SSEL,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [32*NCH-1:0] quad_cnt,
    input  logic [7:0]        din,
    output logic [NCH-1:0]    up,
    output logic [NCH-1:0]    down,
    output logic [DOUTW-1:0]  dout,
    output logic              wd_tripped,
    output logic              frame_ok
);

    localparam logic [7:0] B_QEND = 8'(4*NCH);
    localparam logic [7:0] B_STAT = 8'(4*NCH+1);
    localparam logic [7:0] B_SEQL = 8'(4*NCH+2);
    localparam logic [7:0] B_SEQH = 8'(4*NCH+3);
    localparam logic [7:0] B_DLO  = 8'(2*NCH);
    localparam logic [7:0] B_DHI  = 8'(2*NCH+1);
    localparam logic [7:0] B_CTRL = 8'(2*NCH+2);
    localparam logic [7:0] B_LAST = 8'(4*NCH+4);
    localparam int WDW = $clog2(WD_CYCLES+1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES-1);

    logic [2:0] sck_s, ssel_s;
    logic [1:0] mosi_s;
    logic sck_rise, sck_fall, ssel_fall, ssel_rise, sel, commit;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt, tx_sr, wr_byte, rd_byte;
    logic [6:0] rx_sr;

    logic [32*NCH-1:0] snap_quad;
    logic [7:0]  snap_din, snap_stat;
    logic [15:0] snap_seq;

    // mode nibble: {dir, pdm, down-invert, up-invert}
    logic [PWMBITS-1:0] sh_duty [NCH];
    logic [3:0]         sh_mode [NCH];
    logic [DOUTW-1:0]   sh_dout;
    logic [1:0]         sh_ctrl;
    logic [PWMBITS-1:0] act_duty [NCH];
    logic [3:0]         act_mode [NCH];
    logic [DOUTW-1:0]   act_dout;
    logic [1:0]         act_ctrl;

    logic [15:0]    seq;
    logic [3:0]     err_cnt;
    logic [WDW-1:0] wd_cnt;

    logic [PWMBITS-1:0] pwm_cnt, pwm_rev, cmp;
    logic [NCH-1:0] up_d, down_d;
    logic en, hit;

    assign sck_rise  = sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~sck_s[1] & sck_s[2];
    assign ssel_fall = ~ssel_s[1] & ssel_s[2];
    assign ssel_rise = ssel_s[1] & ~ssel_s[2];
    assign sel       = ~ssel_s[1];
    assign wr_byte   = {rx_sr, mosi_s[1]};
    assign commit    = ssel_rise && byte_cnt == B_LAST && bit_cnt == 3'd0;
    assign MISO      = ~SSEL & sel & tx_sr[7];
    assign dout      = wd_tripped ? '0 : act_dout;
    assign en        = act_ctrl[1] & ~wd_tripped;

    always_comb begin
        rd_byte = 8'h00;
        if (byte_cnt < B_QEND) rd_byte = snap_quad[8*byte_cnt +: 8];
        else if (byte_cnt == B_QEND) rd_byte = snap_din;
        else if (byte_cnt == B_STAT) rd_byte = snap_stat;
        else if (byte_cnt == B_SEQL) rd_byte = snap_seq[7:0];
        else if (byte_cnt == B_SEQH) rd_byte = snap_seq[15:8];
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            sck_s     <= 3'b000;
            ssel_s    <= 3'b111;
            mosi_s    <= 2'b00;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 8'd0;
            rx_sr     <= 7'd0;
            tx_sr     <= 8'd0;
            snap_quad <= '0;
            snap_din  <= 8'd0;
            snap_stat <= 8'd0;
            snap_seq  <= 16'd0;
            sh_dout   <= '0;
            sh_ctrl   <= 2'b00;
            for (int i = 0; i < NCH; i++) begin
                sh_duty[i] <= '0;
                sh_mode[i] <= 4'd0;
            end
        end else begin
            sck_s  <= {sck_s[1:0], SCK};
            ssel_s <= {ssel_s[1:0], SSEL};
            mosi_s <= {mosi_s[0], MOSI};
            if (ssel_fall) begin
                bit_cnt   <= 3'd0;
                byte_cnt  <= 8'd0;
                snap_quad <= quad_cnt;
                snap_din  <= din;
                snap_stat <= {wd_tripped, 3'b000, err_cnt};
                snap_seq  <= seq;
                tx_sr     <= quad_cnt[7:0];
            end else if (sel && sck_rise) begin
                rx_sr   <= wr_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
                    for (int i = 0; i < NCH; i++) begin
                        for (int b = 0; b < PWMBITS; b++) begin
                            if (b < 8 && byte_cnt == 8'(2*i))
                                sh_duty[i][b] <= wr_byte[b%8];
                            if (b >= 8 && byte_cnt == 8'(2*i+1))
                                sh_duty[i][b] <= wr_byte[b%8];
                        end
                        if (byte_cnt == 8'(2*i+1)) sh_mode[i] <= wr_byte[7:4];
                    end
                    for (int b = 0; b < DOUTW; b++) begin
                        if (b < 8 && byte_cnt == B_DLO) sh_dout[b] <= wr_byte[b%8];
                        if (b >= 8 && byte_cnt == B_DHI) sh_dout[b] <= wr_byte[b%8];
                    end
                    if (byte_cnt == B_CTRL) sh_ctrl <= wr_byte[1:0];
                end
            end else if (sel && sck_fall) begin
                // bit_cnt wrapped to 0: byte_cnt already points at the next byte
                tx_sr <= (bit_cnt == 3'd0) ? rd_byte : {tx_sr[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            act_dout   <= '0;
            act_ctrl   <= 2'b00;
            seq        <= 16'd0;
            err_cnt    <= 4'd0;
            wd_cnt     <= '0;
            wd_tripped <= 1'b1;
            frame_ok   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                act_duty[i] <= '0;
                act_mode[i] <= 4'd0;
            end
        end else begin
            frame_ok <= commit;
            if (commit) begin
                for (int i = 0; i < NCH; i++) begin
                    act_duty[i] <= sh_duty[i];
                    act_mode[i] <= sh_mode[i];
                end
                act_dout <= sh_dout;
                act_ctrl <= sh_ctrl;
                seq      <= seq + 16'd1;
                wd_cnt   <= '0;
                if (sh_ctrl[0]) wd_tripped <= 1'b0;
            end else begin
                if (ssel_rise && err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
                if (wd_cnt == WD_LAST) begin
                    wd_tripped <= 1'b1;
                    act_dout   <= '0;
                end else begin
                    wd_cnt <= wd_cnt + WDW'(1);
                end
            end
        end
    end

    always_comb begin
        pwm_rev = pwm_cnt;
        for (int k = 0; k < PWMBITS-4; k++) pwm_rev[4+k] = pwm_cnt[PWMBITS-1-k];
    end

    always_comb begin
        up_d   = '0;
        down_d = '0;
        cmp    = '0;
        hit    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cmp       = act_mode[i][2] ? pwm_rev : pwm_cnt;
            hit       = act_duty[i] > cmp;
            up_d[i]   = act_mode[i][0] ^ (~act_mode[i][3] & hit & en);
            down_d[i] = act_mode[i][1] ^ (act_mode[i][3] & hit & en);
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            pwm_cnt <= '0;
            up      <= '0;
            down    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWMBITS'(1);
            up      <= up_d;
            down    <= down_d;
        end
    end

endmodule

// File: tb/tb_pluto_spi_servo_frame.sv
// Directed bench for pluto_spi_servo_frame: NCH=4, 20-byte frames,
// short watchdog so silence can be provoked quickly.
module tb_pluto_spi_servo_frame;

    localparam int WD = 8000;

    logic clk = 1'b0;
    logic nRESET = 1'b0;
    logic SCK = 1'b0;
    logic SSEL = 1'b1;
    logic MOSI = 1'b0;
    logic MISO;
    logic [127:0] quad_cnt = '0;
    logic [7:0] din = 8'h00;
    logic [3:0] up, down;
    logic [9:0] dout;
    logic wd_tripped, frame_ok;

    int n_vec = 0;
    int n_miss = 0;
    int ok_cnt = 0;
    int ok_base;
    bit mid_chg = 1'b0;
    logic [7:0] txb [24];
    logic [7:0] rxb [24];

    pluto_spi_servo_frame #(
        .NCH(4), .PWMBITS(11), .DOUTW(10), .WD_CYCLES(WD)
    ) dut (
        .clk(clk), .nRESET(nRESET), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI),
        .MISO(MISO), .quad_cnt(quad_cnt), .din(din), .up(up), .down(down),
        .dout(dout), .wd_tripped(wd_tripped), .frame_ok(frame_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_ok === 1'b1) ok_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        MOSI = b;
        repeat (4) @(negedge clk);
        SCK = 1'b1;
        r = MISO;
        repeat (4) @(negedge clk);
        SCK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) spi_bit(t[i], r[i]);
    endtask

    task automatic spi_frame(input int nbytes, input int xbits);
        logic dummy;
        ok_base = ok_cnt;
        SSEL = 1'b0;
        repeat (8) @(negedge clk);
        for (int n = 0; n < nbytes; n++) begin
            if (mid_chg && n == 2) quad_cnt[63:32] = 32'hDEADBEEF;
            spi_byte(txb[n], rxb[n]);
        end
        for (int k = 0; k < xbits; k++) spi_bit(1'b1, dummy);
        repeat (8) @(negedge clk);
        SSEL = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic count_hi(input int ncyc, input int ch,
                            output int nu, output int nd);
        nu = 0;
        nd = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (up[ch]) nu++;
            if (down[ch]) nd++;
        end
    endtask

    initial begin
        int nu, nd;
        logic [7:0] tmp;
        for (int i = 0; i < 24; i++) txb[i] = 8'h00;

        repeat (4) @(negedge clk);
        nRESET = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_wd", wd_tripped, 1);
        chk("rst_up", up, 0);
        chk("rst_down", down, 0);
        chk("rst_dout", dout, 0);
        chk("rst_miso", MISO, 0);
        chk("rst_ok", ok_cnt, 0);

        // frame A: pwm0 duty 1024, dout 0x3A5, enable + wd_clear
        txb[0] = 8'h00; txb[1] = 8'h04;
        txb[8] = 8'hA5; txb[9] = 8'h03; txb[10] = 8'h03;
        quad_cnt = {32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D};
        din = 8'h5A;
        mid_chg = 1'b1;
        spi_frame(20, 0);
        mid_chg = 1'b0;
        chk("A_ok", ok_cnt - ok_base, 1);
        chk("A_wd", wd_tripped, 0);
        chk("A_dout", dout, 10'h3A5);
        chk("A_q0", {rxb[3], rxb[2], rxb[1], rxb[0]}, 32'hCAFEF00D);
        chk("A_q1", {rxb[7], rxb[6], rxb[5], rxb[4]}, 32'h12345678);
        chk("A_din", rxb[16], 8'h5A);
        chk("A_stat", rxb[17], 8'h80);
        chk("A_seq", {rxb[19], rxb[18]}, 0);
        count_hi(2048, 0, nu, nd);
        chk("A_up0_duty", nu, 1024);
        chk("A_dn0_duty", nd, 0);

        // frame B: ch1 dir=1, down-invert, duty 0
        txb[3] = 8'hA0;
        spi_frame(20, 0);
        chk("B_ok", ok_cnt - ok_base, 1);
        chk("B_stat", rxb[17], 8'h00);
        chk("B_seq", {rxb[19], rxb[18]}, 1);
        chk("B_q1", {rxb[7], rxb[6], rxb[5], rxb[4]}, 32'hDEADBEEF);
        count_hi(256, 1, nu, nd);
        chk("B_up1", nu, 0);
        chk("B_dn1", nd, 256);

        // malformed frames must be discarded
        txb[8] = 8'hFF; txb[9] = 8'h00;
        spi_frame(19, 0);
        chk("S19_ok", ok_cnt - ok_base, 0);
        chk("S19_dout", dout, 10'h3A5);
        spi_frame(20, 3);
        chk("S20x_ok", ok_cnt - ok_base, 0);
        chk("S20x_dout", dout, 10'h3A5);
        chk("S20x_err", rxb[17], 8'h01);
        txb[8] = 8'hA5; txb[9] = 8'h03;
        spi_frame(20, 0);
        chk("C_ok", ok_cnt - ok_base, 1);
        chk("C_err", rxb[17], 8'h02);
        chk("C_seq", {rxb[19], rxb[18]}, 2);
        chk("C_miso_idle", MISO, 0);

        // host silence
        repeat (WD + 20) @(negedge clk);
        chk("WD_trip", wd_tripped, 1);
        chk("WD_dout", dout, 0);
        chk("WD_up", up, 0);
        chk("WD_down", down, 4'b0010);

        txb[10] = 8'h02;
        spi_frame(20, 0);
        chk("D_ok", ok_cnt - ok_base, 1);
        chk("D_stat", rxb[17], 8'h82);
        chk("D_wd", wd_tripped, 1);
        txb[10] = 8'h03;
        spi_frame(20, 0);
        chk("E_ok", ok_cnt - ok_base, 1);
        chk("E_seq", {rxb[19], rxb[18]}, 4);
        chk("E_wd", wd_tripped, 0);
        chk("E_dout", dout, 10'h3A5);

        // reset in the middle of a frame
        ok_base = ok_cnt;
        SSEL = 1'b0;
        repeat (8) @(negedge clk);
        for (int n = 0; n < 10; n++) spi_byte(txb[n], tmp);
        nRESET = 1'b0;
        repeat (3) @(negedge clk);
        SSEL = 1'b1;
        repeat (3) @(negedge clk);
        chk("R_dout", dout, 0);
        chk("R_up", up, 0);
        chk("R_down", down, 0);
        chk("R_miso", MISO, 0);
        nRESET = 1'b1;
        repeat (10) @(negedge clk);
        chk("R_ok", ok_cnt - ok_base, 0);
        chk("R_wd", wd_tripped, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
